// File: rtl/mac_clk_seq_pkg.sv
// ---------------------------------------------------------------------------
// mac_clk_seq_pkg
// Shared types and constants for the GMAC/MDIO clock-switch sequencer.
//   state_t     : sequencer FSM states (3-bit encoding)
//   SEL_*       : clkgen clock-select encodings
//   clkCfg_t    : the four clkgen configuration fields, moved as one unit
// ---------------------------------------------------------------------------
package mac_clk_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GATE_OFF = 3'd1,
      ST_SWITCH   = 3'd2,
      ST_SETTLE   = 3'd3,
      ST_GATE_ON  = 3'd4,
      ST_RST_REL  = 3'd5
   } state_t;

   localparam logic [1:0] SEL_OWN_PAD   = 2'b00;
   localparam logic [1:0] SEL_OTHER_PAD = 2'b01;
   localparam logic [1:0] SEL_MCLK      = 2'b10;

   typedef struct packed {
      logic [1:0] txSel;
      logic [1:0] rxSel;
      logic [1:0] mdioSel;
      logic [7:0] div;
   } clkCfg_t;

   // Builds the power-on configuration: every clock on mclk, divider at default
   function automatic clkCfg_t resetCfg(input logic [7:0] defDiv);
      clkCfg_t cfg;
      cfg.txSel   = SEL_MCLK;
      cfg.rxSel   = SEL_MCLK;
      cfg.mdioSel = SEL_MCLK;
      cfg.div     = defDiv;
      return cfg;
   endfunction

endpackage

// File: rtl/mac_clk_seq_wcnt.sv
// ---------------------------------------------------------------------------
// mac_clk_seq_wcnt
// Wait-state down-counter shared by every timed state of the sequencer.
// Ports:
//   i_clk      : clock
//   i_load     : load i_loadVal (has priority over decrement)
//   i_loadVal  : value loaded; a state lasting N cycles loads N-1
//   i_dec      : decrement by one, holding at zero
//   o_zero     : count has reached zero
// The owner keeps i_load asserted during its reset, so no reset is needed here.
// ---------------------------------------------------------------------------
module mac_clk_seq_wcnt #(
   parameter int CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_loadVal,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   // Load wins over decrement; the count parks at zero until the next load
   always_ff @(posedge i_clk) begin
      if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/mac_clk_switch_seq.sv
// ---------------------------------------------------------------------------
// mac_clk_switch_seq
// Sequences run-time changes of the GMAC/MDIO clock configuration fed to
// clkgen: gate MAC clocks and hold MAC reset, switch selects, settle, ungate,
// then release reset.
// Ports:
//   mclk, reset                : clock, synchronous active-high reset
//   req_* (tx/rx/mdio sel, div): requested configuration, sampled on apply
//   apply                      : 1-cycle pulse starting a switch
//   cfg_*                      : configuration driven to clkgen
//   mac_clk_gate_en            : 1 = MAC tx/rx clocks running
//   mac_reset_n                : active-low MAC reset
//   busy, done, apply_ign      : status; done/apply_ign are 1-cycle pulses
//   sw_cnt                     : completed real switches (optional)
// Build option: define MAC_CLK_SEQ_SWCNT_EN to get a saturating switch
// counter on sw_cnt; otherwise sw_cnt is tied to zero.
// ---------------------------------------------------------------------------
module mac_clk_switch_seq
   import mac_clk_seq_pkg::*;
#(
   parameter int         GATE_WAIT   = 8,
   parameter int         SETTLE_WAIT = 16,
   parameter int         RST_HOLD    = 4,
   parameter logic [7:0] DEF_DIV     = 8'h10,
   parameter int         CNT_W       = 5
) (
   input  logic       mclk,
   input  logic       reset,
   input  logic [1:0] req_tx_clk_sel,
   input  logic [1:0] req_rx_clk_sel,
   input  logic [1:0] req_mdio_refclk_sel,
   input  logic [7:0] req_mdio_div_ratio,
   input  logic       apply,
   output logic [1:0] cfg_mac_tx_clk_sel,
   output logic [1:0] cfg_mac_rx_clk_sel,
   output logic [1:0] cfg_mac_mdio_refclk_sel,
   output logic [7:0] cfg_mdio_clk_div_ratio,
   output logic       mac_clk_gate_en,
   output logic       mac_reset_n,
   output logic       busy,
   output logic       done,
   output logic       apply_ign,
   output logic [7:0] sw_cnt
);

   // Every wait must be at least one cycle and fit in the shared counter
   if (GATE_WAIT < 1 || SETTLE_WAIT < 1 || RST_HOLD < 1 ||
       GATE_WAIT >= (1 << CNT_W) || SETTLE_WAIT >= (1 << CNT_W) ||
       RST_HOLD >= (1 << CNT_W)) begin : g_badWaitParam
      $error("mac_clk_switch_seq: wait parameters must be >=1 and < 2**CNT_W");
   end

   localparam clkCfg_t RESET_CFG = resetCfg(DEF_DIV);

   state_t           r_state;
   clkCfg_t          r_cfg;
   clkCfg_t          r_shadow;
   logic             r_gateEn;
   logic             r_macResetN;
   logic             r_busy;
   logic             r_done;
   logic             r_applyIgn;
   logic             r_startup;
   clkCfg_t          w_reqCfg;
   logic             w_cntLoad;
   logic [CNT_W-1:0] w_cntLoadVal;
   logic             w_cntDec;
   logic             w_cntZero;

   assign w_reqCfg = {req_tx_clk_sel, req_rx_clk_sel, req_mdio_refclk_sel, req_mdio_div_ratio};

   // Counter is preloaded one state ahead so each timed state lasts exactly
   // its parameter: GATE_OFF's value sits ready in IDLE, SETTLE's is loaded in
   // SWITCH, GATE_ON's on the last SETTLE cycle. Reset preloads SETTLE for the
   // startup sequence.
   always_comb begin
      w_cntLoad    = 1'b0;
      w_cntLoadVal = '0;
      w_cntDec     = 1'b0;
      if (reset) begin
         w_cntLoad    = 1'b1;
         w_cntLoadVal = CNT_W'(SETTLE_WAIT - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_cntLoad    = 1'b1;
               w_cntLoadVal = CNT_W'(GATE_WAIT - 1);
            end
            ST_SWITCH: begin
               w_cntLoad    = 1'b1;
               w_cntLoadVal = CNT_W'(SETTLE_WAIT - 1);
            end
            ST_SETTLE: begin
               w_cntLoad    = w_cntZero;
               w_cntLoadVal = CNT_W'(RST_HOLD - 1);
               w_cntDec     = 1'b1;
            end
            ST_GATE_OFF, ST_GATE_ON: begin
               w_cntDec = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   mac_clk_seq_wcnt #(
      .CNT_W (CNT_W)
   ) u_wcnt (
      .i_clk     (mclk),
      .i_load    (w_cntLoad),
      .i_loadVal (w_cntLoadVal),
      .i_dec     (w_cntDec),
      .o_zero    (w_cntZero)
   );

   // Sequencer. Outputs are registered with the values of the state being
   // entered. r_startup marks the post-reset pass so it ends without a done
   // pulse. done is raised for the RST_REL cycle; busy falls and MAC reset
   // releases together on the way into IDLE.
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_state     <= ST_SETTLE;
         r_cfg       <= RESET_CFG;
         r_shadow    <= '0;
         r_gateEn    <= 1'b0;
         r_macResetN <= 1'b0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_applyIgn  <= 1'b0;
         r_startup   <= 1'b1;
      end else begin
         r_done     <= 1'b0;
         r_applyIgn <= apply && (r_state != ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (apply) begin
                  r_shadow <= w_reqCfg;
                  if (w_reqCfg == r_cfg) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state     <= ST_GATE_OFF;
                     r_gateEn    <= 1'b0;
                     r_macResetN <= 1'b0;
                     r_busy      <= 1'b1;
                  end
               end
            end
            ST_GATE_OFF: begin
               if (w_cntZero) begin
                  r_state <= ST_SWITCH;
               end
            end
            ST_SWITCH: begin
               r_cfg   <= r_shadow;
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (w_cntZero) begin
                  r_state  <= ST_GATE_ON;
                  r_gateEn <= 1'b1;
               end
            end
            ST_GATE_ON: begin
               if (w_cntZero) begin
                  r_state <= ST_RST_REL;
                  r_done  <= ~r_startup;
               end
            end
            ST_RST_REL: begin
               r_state     <= ST_IDLE;
               r_macResetN <= 1'b1;
               r_busy      <= 1'b0;
               r_startup   <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MAC_CLK_SEQ_SWCNT_EN
   logic [7:0] r_swCnt;

   // Counts real switches as they complete (same edge that raises done);
   // no-op applies and the startup pass never count. Saturates at 8'hFF.
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_swCnt <= 8'h00;
      end else if ((r_state == ST_GATE_ON) && w_cntZero && !r_startup &&
                   (r_swCnt != 8'hFF)) begin
         r_swCnt <= r_swCnt + 8'h01;
      end
   end

   assign sw_cnt = r_swCnt;
`else
   assign sw_cnt = 8'h00;
`endif

   assign cfg_mac_tx_clk_sel      = r_cfg.txSel;
   assign cfg_mac_rx_clk_sel      = r_cfg.rxSel;
   assign cfg_mac_mdio_refclk_sel = r_cfg.mdioSel;
   assign cfg_mdio_clk_div_ratio  = r_cfg.div;
   assign mac_clk_gate_en         = r_gateEn;
   assign mac_reset_n             = r_macResetN;
   assign busy                    = r_busy;
   assign done                    = r_done;
   assign apply_ign               = r_applyIgn;

endmodule
